// File: rtl/phy_rx_deser.sv
// Receive deserializer for the 4-lane PHY link: aligns to IDLE_SYM bytes, then deals bytes round-robin onto four lanes.
// Optional build macro PHY_RX_BYTECNT_EN adds the rx_byte_cnt valid-byte counter output.
module phy_rx_deser #(
  parameter logic [7:0] IDLE_SYM   = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        serial_in,
  output logic [7:0]  out0,
  output logic [7:0]  out1,
  output logic [7:0]  out2,
  output logic [7:0]  out3,
  output logic        valid_out0,
  output logic        valid_out1,
  output logic        valid_out2,
  output logic        valid_out3,
  output logic        active
`ifdef PHY_RX_BYTECNT_EN
  ,
  output logic [15:0] rx_byte_cnt
`endif
);

  typedef enum logic [1:0] {ST_UNSYNC, ST_ALIGNING, ST_ACTIVE} state_e;

  localparam logic [3:0] SYNC_CNT = SYNC_COUNT[3:0];

  state_e     state_q, state_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [1:0] lane_ptr_q, lane_ptr_d;
  logic [7:0] hold_q [3];
  logic [7:0] hold_d [3];
  logic [2:0] hv_q, hv_d;
  logic [7:0] out_q [4];
  logic [7:0] out_d [4];
  logic [3:0] valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] cand;
  logic       is_idle;
  logic       boundary;

  // The byte whose last bit is on serial_in right now.
  assign cand     = {sr_q, serial_in};
  assign is_idle  = (cand == IDLE_SYM);
  assign boundary = (bit_cnt_q == 3'd7);

`ifdef PHY_RX_BYTECNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] frame_valid_cnt;

  assign frame_valid_cnt = {15'd0, hv_q[0]} + {15'd0, hv_q[1]} +
                           {15'd0, hv_q[2]} + {15'd0, ~is_idle};
  assign rx_byte_cnt     = byte_cnt_q;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    sr_d       = cand[6:0];
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    lane_ptr_d = lane_ptr_q;
    hold_d     = hold_q;
    hv_d       = hv_q;
    out_d      = out_q;
    valid_d    = valid_q;
    active_d   = active_q;
`ifdef PHY_RX_BYTECNT_EN
    byte_cnt_d = byte_cnt_q;
`endif

    unique case (state_q)
      ST_UNSYNC: begin
        if (is_idle) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (SYNC_CNT == 4'd1) begin
            state_d    = ST_ACTIVE;
            active_d   = 1'b1;
            lane_ptr_d = 2'd0;
          end else begin
            state_d = ST_ALIGNING;
          end
        end
      end

      ST_ALIGNING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (!is_idle) begin
            bc_cnt_d = 4'd0;
            state_d  = ST_UNSYNC;
          end else if (bc_cnt_q + 4'd1 == SYNC_CNT) begin
            bc_cnt_d   = bc_cnt_q + 4'd1;
            state_d    = ST_ACTIVE;
            active_d   = 1'b1;
            lane_ptr_d = 2'd0;
          end else begin
            bc_cnt_d = bc_cnt_q + 4'd1;
          end
        end
      end

      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          lane_ptr_d = lane_ptr_q + 2'd1;
          case (lane_ptr_q)
            2'd0: begin hold_d[0] = cand; hv_d[0] = ~is_idle; end
            2'd1: begin hold_d[1] = cand; hv_d[1] = ~is_idle; end
            2'd2: begin hold_d[2] = cand; hv_d[2] = ~is_idle; end
            default: begin
              // Lane 3 is taken straight from cand so the frame lands on this edge.
              valid_d = {~is_idle, hv_q[2], hv_q[1], hv_q[0]};
              for (int i = 0; i < 3; i++) begin
                if (hv_q[i]) out_d[i] = hold_q[i];
              end
              if (!is_idle) out_d[3] = cand;
`ifdef PHY_RX_BYTECNT_EN
              byte_cnt_d = byte_cnt_q + frame_valid_cnt;
`endif
            end
          endcase
        end
      end

      default: state_d = ST_UNSYNC;
    endcase
  end

  // NOTE: the lane hold bytes are only a few flops, so they are reset like the rest of the state.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_UNSYNC;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      bc_cnt_q   <= '0;
      lane_ptr_q <= '0;
      hold_q     <= '{default: '0};
      hv_q       <= '0;
      out_q      <= '{default: '0};
      valid_q    <= '0;
      active_q   <= 1'b0;
`ifdef PHY_RX_BYTECNT_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      lane_ptr_q <= lane_ptr_d;
      hold_q     <= hold_d;
      hv_q       <= hv_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
`ifdef PHY_RX_BYTECNT_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];
  assign active     = active_q;

endmodule

// File: tb/tb_phy_rx_deser.sv
// Directed bench for phy_rx_deser: sync acquisition, aborted sync, bit-offset alignment, idle lanes, mid-frame reset.
// Counter checks are compiled in when PHY_RX_BYTECNT_EN is defined.
module tb_phy_rx_deser;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic       serial_in;
  logic [7:0] out0, out1, out2, out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       active;
`ifdef PHY_RX_BYTECNT_EN
  logic [15:0] rx_byte_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] outs;
  logic [3:0]  valids;

  assign outs   = {out0, out1, out2, out3};
  assign valids = {valid_out0, valid_out1, valid_out2, valid_out3};

  phy_rx_deser dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .serial_in  (serial_in),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .active     (active)
`ifdef PHY_RX_BYTECNT_EN
    ,
    .rx_byte_cnt(rx_byte_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    serial_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_byte_head(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset_L   = 1'b0;
    serial_in = 1'b0;
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    serial_in = 1'b0;
    #12;
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL reset_active: got %b want 0", active);
    end
    n_cmp++;
    if (outs !== 32'h0) begin
      n_err++; $display("FAIL reset_outs: got %h want 00000000", outs);
    end
    n_cmp++;
    if (valids !== 4'b0000) begin
      n_err++; $display("FAIL reset_valids: got %b want 0000", valids);
    end
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  task automatic test_sync();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte_head(8'hBC);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL sync_early: active got %b want 0 before last BC bit", active);
    end
    send_bit(1'b0);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++; $display("FAIL sync_active: got %b want 1 on last bit of 4th BC", active);
    end
    n_cmp++;
    if (outs !== 32'h0 || valids !== 4'b0000) begin
      n_err++; $display("FAIL sync_outputs: outs %h valids %b want 00000000 0000", outs, valids);
    end
  endtask

  task automatic test_abort();
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL abort_active: got %b want 0 after BC BC BC 55", active);
    end
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL abort_resync_early: got %b want 0 after 3 new BCs", active);
    end
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++; $display("FAIL abort_resync: got %b want 1 after 4 new BCs", active);
    end
  endtask

  task automatic test_offset_frame();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++; $display("FAIL offset_active: got %b want 1", active);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte_head(8'h44);
    n_cmp++;
    if (valids !== 4'b0000 || outs !== 32'h0) begin
      n_err++; $display("FAIL frame1_early: outs %h valids %b want 00000000 0000", outs, valids);
    end
    send_bit(1'b0);
    n_cmp++;
    if (outs !== 32'h11223344) begin
      n_err++; $display("FAIL frame1_outs: got %h want 11223344", outs);
    end
    n_cmp++;
    if (valids !== 4'b1111) begin
      n_err++; $display("FAIL frame1_valids: got %b want 1111", valids);
    end
`ifdef PHY_RX_BYTECNT_EN
    n_cmp++;
    if (rx_byte_cnt !== 16'd4) begin
      n_err++; $display("FAIL cnt_frame1: got %h want 0004", rx_byte_cnt);
    end
`endif
  endtask

  task automatic test_idle_lane();
    send_frame(8'hA1, 8'hBC, 8'hC3, 8'hD4);
    n_cmp++;
    if (outs !== 32'hA122C3D4) begin
      n_err++; $display("FAIL idle1_outs: got %h want a122c3d4", outs);
    end
    n_cmp++;
    if (valids !== 4'b1011) begin
      n_err++; $display("FAIL idle1_valids: got %b want 1011", valids);
    end
    send_frame(8'h01, 8'h02, 8'h03, 8'hBC);
    n_cmp++;
    if (outs !== 32'h010203D4) begin
      n_err++; $display("FAIL idle3_outs: got %h want 010203d4", outs);
    end
    n_cmp++;
    if (valids !== 4'b1110) begin
      n_err++; $display("FAIL idle3_valids: got %b want 1110", valids);
    end
`ifdef PHY_RX_BYTECNT_EN
    n_cmp++;
    if (rx_byte_cnt !== 16'd10) begin
      n_err++; $display("FAIL cnt_idle: got %h want 000a", rx_byte_cnt);
    end
`endif
    // Frame made only of idles: valids drop, bytes hold.
    send_frame(8'hBC, 8'hBC, 8'hBC, 8'hBC);
    n_cmp++;
    if (outs !== 32'h010203D4 || valids !== 4'b0000) begin
      n_err++; $display("FAIL all_idle: outs %h valids %b want 010203d4 0000", outs, valids);
    end
`ifdef PHY_RX_BYTECNT_EN
    n_cmp++;
    if (rx_byte_cnt !== 16'd10) begin
      n_err++; $display("FAIL cnt_all_idle: got %h want 000a", rx_byte_cnt);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h77);
    send_byte(8'h66);
    #2;
    reset_L = 1'b0;
    #1;
    n_cmp++;
    if (active !== 1'b0 || outs !== 32'h0 || valids !== 4'b0000) begin
      n_err++; $display("FAIL midreset: active %b outs %h valids %b want 0 00000000 0000",
                        active, outs, valids);
    end
`ifdef PHY_RX_BYTECNT_EN
    n_cmp++;
    if (rx_byte_cnt !== 16'd0) begin
      n_err++; $display("FAIL cnt_midreset: got %h want 0000", rx_byte_cnt);
    end
`endif
    serial_in = 1'b0;
    @(negedge clk_32f);
    reset_L = 1'b1;
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL midreset_resync_early: got %b want 0", active);
    end
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++; $display("FAIL midreset_resync: got %b want 1", active);
    end
    send_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    n_cmp++;
    if (outs !== 32'h5A6B7C8D || valids !== 4'b1111) begin
      n_err++; $display("FAIL midreset_frame: outs %h valids %b want 5a6b7c8d 1111", outs, valids);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_abort();
    test_offset_frame();
    test_idle_lane();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
